// File: rtl/ntt_host_port_if.sv
// Stream and BRAM port-B bundle for the NTT host port.
// slave: the host-port block; master: the surrounding environment.
interface ntt_host_port_if;
   logic [63:0] s_data;
   logic        s_valid;
   logic        s_ready;
   logic [63:0] m_data;
   logic        m_valid;
   logic        m_ready;
   logic [12:0] BRAM_addr;
   logic        BRAM_clk;
   logic [63:0] BRAM_din;
   logic [63:0] BRAM_dout;
   logic        BRAM_en;
   logic        BRAM_we;

   modport slave (
      input  s_data, s_valid, m_ready, BRAM_dout,
      output s_ready, m_data, m_valid,
      output BRAM_addr, BRAM_clk, BRAM_din, BRAM_en, BRAM_we
   );

   modport master (
      output s_data, s_valid, m_ready, BRAM_dout,
      input  s_ready, m_data, m_valid,
      input  BRAM_addr, BRAM_clk, BRAM_din, BRAM_en, BRAM_we
   );
endinterface

// File: rtl/ntt_host_port.sv
// Host controller on BRAM port B: loads x and w, runs the NTT engine,
// unloads y. Ports: clk/rst, start, bus (streams + BRAM), core_rst/done, busy/done.
module ntt_host_port #(
   parameter int X_BASE       = 0,
   parameter int W_BASE       = 64,
   parameter int Y_BASE       = 4160,
   parameter int N            = 64,
   parameter int READ_LATENCY = 3
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   ntt_host_port_if.slave bus,
   output logic           core_rst,
   input  logic           core_done,
   output logic           busy,
   output logic           done
);
   typedef enum logic [2:0] {
      IDLE, LOAD_X, LOAD_W, RUN, UNLOAD, FINISH
   } state_t;

   state_t      state, state_nx;
   logic [12:0] cnt;
   logic [12:0] addr_q;
   logic [3:0]  lat;
   logic [63:0] din_q;
   logic [63:0] m_data_q;
   logic        we_q;
   logic        m_valid_q;
   logic        s_rdy;
   logic        in_hs;
   logic        out_hs;
   logic        y_last;
   logic        last_in;

   assign s_rdy   = (state == LOAD_X) || (state == LOAD_W);
   assign in_hs   = bus.s_valid && s_rdy;
   assign out_hs  = m_valid_q && bus.m_ready;
   assign y_last  = (cnt == 13'(N - 1));
   assign last_in = (state == LOAD_X) ? y_last
                                      : (cnt == 13'(N * N - 1));

   assign bus.s_ready   = s_rdy;
   assign bus.m_data    = m_data_q;
   assign bus.m_valid   = m_valid_q;
   assign bus.BRAM_clk  = clk;
   assign bus.BRAM_en   = busy;
   assign bus.BRAM_we   = we_q;
   assign bus.BRAM_addr = addr_q;
   assign bus.BRAM_din  = din_q;

   always_comb begin
      state_nx = state;
      core_rst = 1'b1;
      busy     = 1'b1;
      done     = 1'b0;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nx = LOAD_X;
         end
         LOAD_X: if (in_hs && last_in) state_nx = LOAD_W;
         LOAD_W: if (in_hs && last_in) state_nx = RUN;
         RUN: begin
            // keep the engine in reset while the final w write lands
            core_rst = we_q;
            if (core_done) state_nx = UNLOAD;
         end
         UNLOAD: begin
            core_rst = 1'b0;
            if (out_hs && y_last) state_nx = FINISH;
         end
         FINISH: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         lat       <= '0;
         addr_q    <= 13'(X_BASE);
         din_q     <= '0;
         we_q      <= 1'b0;
         m_data_q  <= '0;
         m_valid_q <= 1'b0;
      end else begin
         state <= state_nx;
         we_q  <= 1'b0;
         unique case (state)
            IDLE: if (start) cnt <= '0;
            LOAD_X, LOAD_W: begin
               if (in_hs) begin
                  we_q <= 1'b1;
                  if (state == LOAD_X) begin
                     addr_q <= 13'(X_BASE) + cnt;
                     din_q  <= bus.s_data;
                  end else begin
                     addr_q <= 13'(W_BASE) + cnt;
                     din_q  <= {56'b0, bus.s_data[7:0]};
                  end
                  cnt <= last_in ? '0 : cnt + 13'd1;
               end
            end
            RUN: begin
               if (core_done) begin
                  cnt    <= '0;
                  lat    <= '0;
                  addr_q <= 13'(Y_BASE);
               end
            end
            UNLOAD: begin
               if (out_hs) begin
                  // next read address goes out in the accept cycle
                  m_valid_q <= 1'b0;
                  cnt       <= cnt + 13'd1;
                  lat       <= '0;
                  addr_q    <= 13'(Y_BASE) + cnt + 13'd1;
               end else if (!m_valid_q) begin
                  if (lat == 4'(READ_LATENCY)) begin
                     m_data_q  <= bus.BRAM_dout;
                     m_valid_q <= 1'b1;
                  end else begin
                     lat <= lat + 4'd1;
                  end
               end
            end
            FINISH: begin
               cnt    <= '0;
               addr_q <= 13'(X_BASE);
            end
            default: ;
         endcase
      end
   end
endmodule
